// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, memory
// geometry and requester index constants.
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int MEM_BYTES  = 20;
  localparam int WORD_BYTES = 4;

  // Requester indices
  localparam int REQ_PIPE = 0;   // pipeline load/store
  localparam int REQ_DBG  = 1;   // debug / DMA

  // One-hot vector for a 1-bit requester index
  function automatic logic [1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick.
//   req  : request vector
//   ptr  : index of the last granted requester
//   any  : at least one request present
//   win  : selected requester index (valid when any = 1)
// On a tie the requester not pointed to by ptr wins.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       any,
  output logic       win
);

  always_comb begin
    any = |req;
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~ptr;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates two requesters (pipeline, debug/DMA) onto a single data-memory
// port. Each access takes three cycles: IDLE (arbitrate/latch), ACCESS
// (memory strobe), RESP (completion pulse). All outputs are registered.
//
// Ports
//   clk, reset     : clock, asynchronous active-low reset
//   req/we         : per-requester request and write enable
//   addr/wdata     : per-requester address/store data, 32 bits per requester
//   gnt/rvalid     : one-hot grant and completion pulses
//   rdata/err      : load data and error flag, valid with rvalid
//   mem_*          : data-memory interface
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a request; arbitrate and latch the winner
// ST_ACCESS | gnt pulse, memory strobe, capture response
// ST_RESP   | rvalid pulse with rdata/err
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = dmem_arbiter_pkg::MEM_BYTES,
  parameter int N_REQ     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      we,
  input  logic [32*N_REQ-1:0]   addr,
  input  logic [32*N_REQ-1:0]   wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rvalid,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_rdata
);

  // Highest legal word-aligned start address
  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - WORD_BYTES);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        illegal_q, illegal_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic        arb_any;
  logic        arb_win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_illegal;

  rr_arbiter2 u_rr (
    .req (req),
    .ptr (ptr_q),
    .any (arb_any),
    .win (arb_win)
  );

  always_comb begin
    sel_we      = arb_win ? we[REQ_DBG] : we[REQ_PIPE];
    sel_addr    = arb_win ? addr[32*REQ_DBG +: 32]  : addr[32*REQ_PIPE +: 32];
    sel_wdata   = arb_win ? wdata[32*REQ_DBG +: 32] : wdata[32*REQ_PIPE +: 32];
    sel_illegal = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
  end

  always_comb begin
    // latched fields hold; pulse-type outputs default low
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    we_d        = we_q;
    illegal_d   = illegal_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    rdata_d     = 32'h0;
    err_d       = 1'b0;
    mem_addr_d  = 32'h0;
    mem_wdata_d = 32'h0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d     = ST_ACCESS;
          win_d       = arb_win;
          ptr_d       = arb_win;
          we_d        = sel_we;
          illegal_d   = sel_illegal;
          gnt_d       = idx_onehot(arb_win);
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_read_d  = !sel_we && !sel_illegal;
          mem_write_d = sel_we && !sel_illegal;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_RESP;
        rvalid_d = idx_onehot(win_q);
        err_d    = illegal_q;
        rdata_d  = (we_q || illegal_q) ? 32'h0 : mem_rdata;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      illegal_q   <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      we_q        <= we_d;
      illegal_q   <= illegal_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter with a word-wide memory model.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:4];
  int          n_checks = 0;
  int          n_errors = 0;
  int          strobe_clash = 0;

  dmem_arbiter u_dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // memory: word0=10, word1=20, word2=12, words 3-4 = 0x01 per byte
  always @(posedge clk) begin
    if (!reset) begin
      mem[0] <= 32'd10;
      mem[1] <= 32'd20;
      mem[2] <= 32'd12;
      mem[3] <= 32'h0101_0101;
      mem[4] <= 32'h0101_0101;
    end else if (mem_write && mem_addr < 32'd20) begin
      mem[mem_addr[4:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_addr < 32'd20) ? mem[mem_addr[4:2]] : 32'h0;

  always @(negedge clk) begin
    if (mem_read && mem_write) strobe_clash <= strobe_clash + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 2'b00;
    we    = 2'b00;
    addr  = 64'h0;
    wdata = 64'h0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic issue(input int port, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    req[port]          = 1'b1;
    we[port]           = w;
    addr[32*port +: 32]  = a;
    wdata[32*port +: 32] = d;
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (gnt == 2'b00 && cyc < 8);
    if (gnt == 2'b00) chk("gnt_timeout", 32'(gnt), 32'h1);
  endtask

  // Full single access with hand-computed expectations
  task automatic access(input string tag, input int port, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int         cyc;
    logic [1:0] oh;
    oh = (port == 1) ? 2'b10 : 2'b01;
    issue(port, w, a, d);
    wait_gnt(cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd1);
    chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
    chk({tag, "_maddr"}, mem_addr, a);
    chk({tag, "_mrd"}, 32'(mem_read), 32'(!w && !exp_err));
    chk({tag, "_mwr"}, 32'(mem_write), 32'(w && !exp_err));
    if (w) chk({tag, "_mwdata"}, mem_wdata, d);
    req[port] = 1'b0;
    tick();
    chk({tag, "_rvalid"}, 32'(rvalid), 32'(oh));
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_strobe_off"}, 32'({mem_read, mem_write}), 32'h0);
    chk({tag, "_maddr_off"}, mem_addr, 32'h0);
    tick();
    chk({tag, "_rvalid_off"}, 32'(rvalid), 32'h0);
    chk({tag, "_rdata_off"}, rdata, 32'h0);
  endtask

  initial begin
    int         cyc;
    logic [1:0] exp_g;

    // reset values
    reset = 1'b0;
    req = 2'b00; we = 2'b00; addr = 64'h0; wdata = 64'h0;
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_strobes", 32'({mem_read, mem_write, err}), 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    do_reset();

    // port 0 load at 4
    access("ld4", 0, 1'b0, 32'd4, 32'h0, 32'd20, 1'b0);

    // simultaneous requests, port 0 wins first tie after reset
    do_reset();
    issue(0, 1'b0, 32'd0, 32'h0);
    issue(1, 1'b0, 32'd8, 32'h0);
    wait_gnt(cyc);
    chk("tie_gnt0", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    tick();
    chk("tie_rv0", 32'(rvalid), 32'h1);
    chk("tie_rd0", rdata, 32'd10);
    tick();
    chk("tie_gap", 32'(gnt), 32'h0);
    tick();
    chk("tie_gnt1", 32'(gnt), 32'h2);
    chk("tie_maddr1", mem_addr, 32'd8);
    req[1] = 1'b0;
    tick();
    chk("tie_rv1", 32'(rvalid), 32'h2);
    chk("tie_rd1", rdata, 32'd12);
    tick();

    // port 1 store then load back
    access("st12", 1, 1'b1, 32'd12, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access("ld12", 1, 1'b0, 32'd12, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // illegal and boundary addresses
    access("ld6", 0, 1'b0, 32'd6, 32'h0, 32'h0, 1'b1);
    access("ld20", 0, 1'b0, 32'd20, 32'h0, 32'h0, 1'b1);
    access("ld16", 0, 1'b0, 32'd16, 32'h0, 32'h0101_0101, 1'b0);
    access("st2", 1, 1'b1, 32'd2, 32'h1234_5678, 32'h0, 1'b1);
    access("ldbig", 1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);

    // reset during a store ACCESS
    do_reset();
    access("pre", 1, 1'b0, 32'd0, 32'h0, 32'd10, 1'b0);  // pointer now 1
    issue(0, 1'b1, 32'd4, 32'h5555_AAAA);
    wait_gnt(cyc);
    chk("ab_mwr_on", 32'(mem_write), 32'h1);
    req = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    chk("ab_mwr_async", 32'(mem_write), 32'h0);
    chk("ab_maddr_async", mem_addr, 32'h0);
    chk("ab_gnt_async", 32'(gnt), 32'h0);
    tick();
    chk("ab_no_rvalid_rst", 32'(rvalid), 32'h0);
    reset = 1'b1;
    tick();
    chk("ab_no_rvalid", 32'(rvalid), 32'h0);
    issue(0, 1'b0, 32'd0, 32'h0);
    issue(1, 1'b0, 32'd8, 32'h0);
    wait_gnt(cyc);
    chk("ab_tie_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    tick();

    // continuous requests alternate every 3 cycles
    do_reset();
    issue(0, 1'b0, 32'd0, 32'h0);
    issue(1, 1'b0, 32'd8, 32'h0);
    exp_g = 2'b01;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(cyc);
      chk($sformatf("rr_interval%0d", k), 32'(cyc), (k == 0) ? 32'd1 : 32'd3);
      chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(exp_g));
      exp_g = ~exp_g;
    end
    req = 2'b00;
    tick();
    tick();
    tick();
    chk("strobe_exclusive", 32'(strobe_clash), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
